// File: rtl/dma_tile_arbiter.sv
// Round-robin arbiter sharing one DMA command port between NREQ requesters.
// Serialises whole transfers: grant, issue command, steer beats, pulse done.
module dma_tile_arbiter #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned AW   = 40,
    parameter int unsigned LW   = 16,
    parameter int unsigned DW   = 128
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic [NREQ-1:0]    req_req,
    input  logic [NREQ-1:0]    req_rwn,
    input  logic [NREQ*AW-1:0] req_hostAddr,
    input  logic [NREQ*LW-1:0] req_localAddr,
    input  logic [NREQ*LW-1:0] req_len,
    input  logic [NREQ*DW-1:0] req_writeData,
    output logic [NREQ-1:0]    req_ready,
    output logic [NREQ-1:0]    req_ack,
    output logic [DW-1:0]      req_readData,
    output logic [NREQ-1:0]    req_done,
    output logic               ds_req,
    output logic               ds_rwn,
    output logic [AW-1:0]      ds_hostAddr,
    output logic [LW-1:0]      ds_localAddr,
    output logic [LW-1:0]      ds_len,
    output logic [DW-1:0]      ds_writeData,
    input  logic               ds_ready,
    input  logic               ds_ack,
    input  logic [DW-1:0]      ds_readData,
    output logic               busy,
    output logic [2:0]         grant_idx
);

    typedef enum logic [1:0] {StIdle, StIssue, StXfer} state_e;

    state_e            state_q, state_d;
    logic [2:0]        last_q, last_d;
    logic [2:0]        g_q, g_d;
    logic              rwn_q, rwn_d;
    logic [AW-1:0]     haddr_q, haddr_d;
    logic [LW-1:0]     laddr_q, laddr_d;
    logic [LW-1:0]     len_q, len_d;
    logic [LW-1:0]     count_q, count_d;
    logic [NREQ-1:0]   done_q, done_d;

    logic              found;
    logic [2:0]        pick;
    logic              sel_rwn;
    logic [AW-1:0]     sel_haddr;
    logic [LW-1:0]     sel_laddr;
    logic [LW-1:0]     sel_len;
    logic [DW-1:0]     grant_wdata;
    logic [NREQ-1:0]   grant_oh;

    // Round-robin: first requester above last wins, otherwise wrap to the lowest.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        for (int j = 0; j < NREQ; j++) begin
            if (!found && req_req[j] && (3'(j) > last_q)) begin
                found = 1'b1;
                pick  = 3'(j);
            end
        end
        for (int j = 0; j < NREQ; j++) begin
            if (!found && req_req[j]) begin
                found = 1'b1;
                pick  = 3'(j);
            end
        end
    end

    always_comb begin
        sel_rwn     = 1'b0;
        sel_haddr   = '0;
        sel_laddr   = '0;
        sel_len     = '0;
        grant_wdata = '0;
        grant_oh    = '0;
        for (int j = 0; j < NREQ; j++) begin
            if (3'(j) == pick) begin
                sel_rwn   = req_rwn[j];
                sel_haddr = req_hostAddr[j*AW +: AW];
                sel_laddr = req_localAddr[j*LW +: LW];
                sel_len   = req_len[j*LW +: LW];
            end
            if (3'(j) == g_q) begin
                grant_wdata = req_writeData[j*DW +: DW];
                grant_oh[j] = 1'b1;
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        last_d       = last_q;
        g_d          = g_q;
        rwn_d        = rwn_q;
        haddr_d      = haddr_q;
        laddr_d      = laddr_q;
        len_d        = len_q;
        count_d      = count_q;
        done_d       = '0;
        req_ready    = '0;
        req_ack      = '0;
        req_readData = '0;
        ds_writeData = '0;
        unique case (state_q)
            StIdle: begin
                if (found) begin
                    g_d     = pick;
                    rwn_d   = sel_rwn;
                    haddr_d = sel_haddr;
                    laddr_d = sel_laddr;
                    len_d   = sel_len;
                    state_d = StIssue;
                end
            end
            StIssue: begin
                if (ds_ready) begin
                    req_ready = grant_oh;
                    count_d   = len_q;
                    if (len_q == '0) begin
                        done_d  = grant_oh;
                        last_d  = g_q;
                        state_d = StIdle;
                    end else begin
                        state_d = StXfer;
                    end
                end
            end
            StXfer: begin
                ds_writeData = grant_wdata;
                req_readData = ds_readData;
                // Counter never wraps: a stray ack at zero is dropped.
                if (ds_ack && (count_q != '0)) begin
                    req_ack = grant_oh;
                    count_d = count_q - LW'(1);
                    if (count_q == LW'(1)) begin
                        done_d  = grant_oh;
                        last_d  = g_q;
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= StIdle;
            last_q  <= 3'(NREQ - 1);
            g_q     <= '0;
            rwn_q   <= 1'b0;
            haddr_q <= '0;
            laddr_q <= '0;
            len_q   <= '0;
            count_q <= '0;
            done_q  <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            g_q     <= g_d;
            rwn_q   <= rwn_d;
            haddr_q <= haddr_d;
            laddr_q <= laddr_d;
            len_q   <= len_d;
            count_q <= count_d;
            done_q  <= done_d;
        end
    end

    // Command fields are only presented while the command is being offered.
    assign ds_req       = (state_q == StIssue);
    assign ds_rwn       = ds_req & rwn_q;
    assign ds_hostAddr  = ds_req ? haddr_q : '0;
    assign ds_localAddr = ds_req ? laddr_q : '0;
    assign ds_len       = ds_req ? len_q : '0;
    assign req_done     = done_q;
    assign busy         = (state_q != StIdle);
    assign grant_idx    = g_q;

endmodule
